video_timing_meter: RTL and testbench

- Sits directly downstream of the sync/blank aligner in the video output path.
- Consumes cleaned, positive-polarity HSync/VSync/HBlank/VBlank and measures the incoming video timing: total and active pixels per line, total and active lines per frame, and sync widths.
- Publishes the measured values only once they have stayed identical for a configurable number of consecutive frames.
- Downstream users (scaler setup, OSD, status reporting) read the results with a lock flag and a one-cycle change pulse.

---
 rtl/vtm_pkg.sv | 13 +
 rtl/vtm_line_counter.sv | 27 ++
 rtl/video_timing_meter.sv | 185 ++++++++++++++++++
 tb/tb_video_timing_meter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vtm_pkg.sv
// Shared types for the video timing meter: FSM states and stability-counter sizing.
package vtm_pkg;

  typedef enum logic [1:0] {
    ST_NOSIG = 2'd0,
    ST_ACQ   = 2'd1,
    ST_LOCK  = 2'd2
  } state_t;

  localparam int unsigned MATCH_W = 4;
  localparam logic [MATCH_W-1:0] MATCH_MAX = '1;

endpackage

// File: rtl/vtm_line_counter.sv
// Saturating event counter with count qualifier, synchronous restart and saturation flag.
module vtm_line_counter #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         restart,
  output logic [W-1:0] count,
  output logic         sat_c
);

  // A qualified event arriving while already at all-ones is lost; flag it.
  assign sat_c = inc & ~restart & (count == {W{1'b1}});

  // Restart counts the restarting event itself as the first one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart) begin
      count <= W'(inc);
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/video_timing_meter.sv
// Measures line/frame timing from clean sync/blank inputs and publishes it
// once the same timing has repeated for STABLE_FRAMES consecutive frames.
module video_timing_meter
  import vtm_pkg::*;
#(
  parameter int unsigned HW            = 12,
  parameter int unsigned VW            = 11,
  parameter int unsigned STABLE_FRAMES = 2,
  parameter int unsigned TIMEOUT       = 1048576
) (
  input  logic          clk_vid,
  input  logic          reset_n,
  input  logic          ce_pix,
  input  logic          HSync,
  input  logic          VSync,
  input  logic          HBlank,
  input  logic          VBlank,
  output logic [HW-1:0] h_total,
  output logic [HW-1:0] h_active,
  output logic [HW-1:0] h_sync,
  output logic [VW-1:0] v_total,
  output logic [VW-1:0] v_active,
  output logic [VW-1:0] v_sync,
  output logic          locked,
  output logic          changed
);

  localparam int unsigned TUP_W = 3*HW + 3*VW;
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);
  localparam logic [MATCH_W-1:0] LOCK_CNT = MATCH_W'(STABLE_FRAMES - 1);

  logic          hs_d, vs_d, hs_rise, vs_rise;
  logic [HW-1:0] hcnt, hact, hsw;
  logic [VW-1:0] vcnt, vact, vsw;
  logic [HW-1:0] line_htot, line_hact, line_hsw;
  logic [5:0]    sat;
  logic          frame_ovf, ovf_now;
  logic [TW-1:0] tcnt;
  logic          timeout_hit;
  logic [TUP_W-1:0] cand, prev_tup, prev_nxt, pub, pub_nxt;
  logic          prev_valid, prev_valid_nxt, match_c;
  logic [MATCH_W-1:0] match_cnt, match_nxt, mc_inc;
  logic          locked_nxt, changed_nxt;
  state_t        state, state_nxt;

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      hs_d <= 1'b0;
      vs_d <= 1'b0;
    end else if (ce_pix) begin
      hs_d <= HSync;
      vs_d <= VSync;
    end
  end

  assign hs_rise = ce_pix & HSync & ~hs_d;
  assign vs_rise = ce_pix & VSync & ~vs_d;

  vtm_line_counter #(.W(HW)) u_hcnt (.clk(clk_vid), .rst_n(reset_n), .inc(ce_pix),
    .restart(hs_rise), .count(hcnt), .sat_c(sat[0]));
  vtm_line_counter #(.W(HW)) u_hact (.clk(clk_vid), .rst_n(reset_n), .inc(ce_pix & ~HBlank),
    .restart(hs_rise), .count(hact), .sat_c(sat[1]));
  vtm_line_counter #(.W(HW)) u_hsw (.clk(clk_vid), .rst_n(reset_n), .inc(ce_pix & HSync),
    .restart(hs_rise), .count(hsw), .sat_c(sat[2]));
  vtm_line_counter #(.W(VW)) u_vcnt (.clk(clk_vid), .rst_n(reset_n), .inc(hs_rise),
    .restart(vs_rise), .count(vcnt), .sat_c(sat[3]));
  vtm_line_counter #(.W(VW)) u_vact (.clk(clk_vid), .rst_n(reset_n), .inc(hs_rise & ~VBlank),
    .restart(vs_rise), .count(vact), .sat_c(sat[4]));
  vtm_line_counter #(.W(VW)) u_vsw (.clk(clk_vid), .rst_n(reset_n), .inc(hs_rise & VSync),
    .restart(vs_rise), .count(vsw), .sat_c(sat[5]));

  // Completed-line values plus per-frame overflow tracking.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      line_htot <= '0;
      line_hact <= '0;
      line_hsw  <= '0;
      frame_ovf <= 1'b0;
    end else begin
      if (hs_rise) begin
        line_htot <= hcnt;
        line_hact <= hact;
        line_hsw  <= hsw;
      end
      if (vs_rise)   frame_ovf <= 1'b0;
      else if (|sat) frame_ovf <= 1'b1;
    end
  end

  assign ovf_now = frame_ovf | (|sat);

  // A line ending on this very strobe is the last completed line of the frame.
  assign cand = hs_rise ? {hcnt, hact, hsw, vcnt, vact, vsw}
                        : {line_htot, line_hact, line_hsw, vcnt, vact, vsw};

  // No-signal watchdog: fires once when TIMEOUT clocks pass without a line start.
  assign timeout_hit = ~hs_rise & (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n)                  tcnt <= '0;
    else if (hs_rise)              tcnt <= '0;
    else if (tcnt != TW'(TIMEOUT)) tcnt <= tcnt + TW'(1);
  end

  assign match_c = prev_valid & ~ovf_now & (cand == prev_tup);
  assign mc_inc  = !match_c ? '0 :
                   (match_cnt == MATCH_MAX) ? MATCH_MAX : match_cnt + MATCH_W'(1);

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_NOSIG;
      match_cnt  <= '0;
      prev_tup   <= '0;
      prev_valid <= 1'b0;
      pub        <= '0;
      locked     <= 1'b0;
      changed    <= 1'b0;
    end else begin
      state      <= state_nxt;
      match_cnt  <= match_nxt;
      prev_tup   <= prev_nxt;
      prev_valid <= prev_valid_nxt;
      pub        <= pub_nxt;
      locked     <= locked_nxt;
      changed    <= changed_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    match_nxt      = match_cnt;
    prev_nxt       = prev_tup;
    prev_valid_nxt = prev_valid;
    pub_nxt        = pub;
    locked_nxt     = locked;
    changed_nxt    = 1'b0;
    if (timeout_hit) begin
      state_nxt      = ST_NOSIG;
      match_nxt      = '0;
      prev_valid_nxt = 1'b0;
      pub_nxt        = '0;
      locked_nxt     = 1'b0;
      changed_nxt    = locked;
    end else if (vs_rise) begin
      case (state)
        ST_NOSIG: begin
          // First frame start only arms measurement; the partial frame is dropped.
          state_nxt      = ST_ACQ;
          match_nxt      = '0;
          prev_valid_nxt = 1'b0;
        end
        ST_ACQ: begin
          match_nxt      = mc_inc;
          prev_nxt       = cand;
          prev_valid_nxt = ~ovf_now;
          if (!ovf_now && (mc_inc >= LOCK_CNT)) begin
            state_nxt   = ST_LOCK;
            pub_nxt     = cand;
            locked_nxt  = 1'b1;
            changed_nxt = 1'b1;
          end
        end
        ST_LOCK: begin
          match_nxt      = mc_inc;
          prev_nxt       = cand;
          prev_valid_nxt = ~ovf_now;
          if (!match_c) begin
            state_nxt   = ST_ACQ;
            locked_nxt  = 1'b0;
            changed_nxt = 1'b1;
          end
        end
        default: state_nxt = ST_NOSIG;
      endcase
    end
  end

  assign h_total  = pub[TUP_W-1      -: HW];
  assign h_active = pub[TUP_W-HW-1   -: HW];
  assign h_sync   = pub[TUP_W-2*HW-1 -: HW];
  assign v_total  = pub[3*VW-1       -: VW];
  assign v_active = pub[2*VW-1       -: VW];
  assign v_sync   = pub[VW-1:0];

endmodule

// File: tb/tb_video_timing_meter.sv
// Randomized bench for video_timing_meter: a wide instance and a narrow (6/5-bit) instance share
// one video stream and are checked at every frame start against a frame-level reference model.
module tb_video_timing_meter;

  localparam int unsigned HW0 = 12, VW0 = 11, SF0 = 2, TO0 = 1000;
  localparam int unsigned HW1 = 6,  VW1 = 5,  SF1 = 1, TO1 = 4096;
  localparam int          HMAX1 = 63;

  typedef logic [5:0][15:0] tup_t;

  logic clk_vid, reset_n, ce_pix, HSync, VSync, HBlank, VBlank;
  logic [HW0-1:0] h_total0, h_active0, h_sync0;
  logic [VW0-1:0] v_total0, v_active0, v_sync0;
  logic           locked0, changed0;
  logic [HW1-1:0] h_total1, h_active1, h_sync1;
  logic [VW1-1:0] v_total1, v_active1, v_sync1;
  logic           locked1, changed1;

  video_timing_meter #(.HW(HW0), .VW(VW0), .STABLE_FRAMES(SF0), .TIMEOUT(TO0)) dut0 (
    .clk_vid(clk_vid), .reset_n(reset_n), .ce_pix(ce_pix), .HSync(HSync), .VSync(VSync),
    .HBlank(HBlank), .VBlank(VBlank), .h_total(h_total0), .h_active(h_active0),
    .h_sync(h_sync0), .v_total(v_total0), .v_active(v_active0), .v_sync(v_sync0),
    .locked(locked0), .changed(changed0));

  video_timing_meter #(.HW(HW1), .VW(VW1), .STABLE_FRAMES(SF1), .TIMEOUT(TO1)) dut1 (
    .clk_vid(clk_vid), .reset_n(reset_n), .ce_pix(ce_pix), .HSync(HSync), .VSync(VSync),
    .HBlank(HBlank), .VBlank(VBlank), .h_total(h_total1), .h_active(h_active1),
    .h_sync(h_sync1), .v_total(v_total1), .v_active(v_active1), .v_sync(v_sync1),
    .locked(locked1), .changed(changed1));

  initial clk_vid = 1'b0;
  always #5 clk_vid = ~clk_vid;

  int n_tests = 0;
  int n_fail  = 0;
  string fname [6] = '{"v_sync", "v_active", "v_total", "h_sync", "h_active", "h_total"};

  // Reference model state, one slot per instance.
  bit   m_active [2];
  bit   m_locked [2];
  bit   m_pvalid [2];
  int   m_run    [2];
  tup_t m_prev   [2];
  tup_t m_pub    [2];
  int   m_nchg   [2];
  bit   exp_chg  [2];
  int   seen     [2];

  tup_t rec;
  bit   rec_ovf1;
  int   ce_gap_mode;
  int   vt, va, vs, ht, ha, hs;

  always @(negedge clk_vid) begin
    if (changed0) seen[0]++;
    if (changed1) seen[1]++;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sf_of(input int d);
    return (d == 0) ? int'(SF0) : int'(SF1);
  endfunction

  function automatic tup_t get_out(input int d);
    tup_t t;
    if (d == 0) begin
      t[0] = 16'(v_sync0);  t[1] = 16'(v_active0); t[2] = 16'(v_total0);
      t[3] = 16'(h_sync0);  t[4] = 16'(h_active0); t[5] = 16'(h_total0);
    end else begin
      t[0] = 16'(v_sync1);  t[1] = 16'(v_active1); t[2] = 16'(v_total1);
      t[3] = 16'(h_sync1);  t[4] = 16'(h_active1); t[5] = 16'(h_total1);
    end
    return t;
  endfunction

  // Frame-level rule: a frame is usable if nothing overflowed; lock once the last
  // sf usable frames are identical; a locked meter drops on any differing/unusable frame.
  task automatic model_end(input int d, input tup_t t, input bit ovf);
    bit valid, eq;
    exp_chg[d] = 1'b0;
    if (!m_active[d]) begin
      m_active[d] = 1'b1;
      m_pvalid[d] = 1'b0;
      m_run[d]    = 0;
    end else begin
      valid    = !ovf;
      eq       = valid && m_pvalid[d] && (t == m_prev[d]);
      m_run[d] = eq ? m_run[d] + 1 : (valid ? 1 : 0);
      if (m_locked[d]) begin
        if (!eq) begin
          m_locked[d] = 1'b0;
          exp_chg[d]  = 1'b1;
        end
      end else if (valid && m_run[d] >= sf_of(d)) begin
        m_locked[d] = 1'b1;
        m_pub[d]    = t;
        exp_chg[d]  = 1'b1;
      end
      m_prev[d]   = t;
      m_pvalid[d] = valid;
    end
    if (exp_chg[d]) m_nchg[d]++;
  endtask

  task automatic model_clear(input int d, input bit on_timeout);
    if (on_timeout && m_locked[d]) m_nchg[d]++;
    m_locked[d] = 1'b0;
    m_pub[d]    = '0;
    m_active[d] = 1'b0;
    m_pvalid[d] = 1'b0;
    m_run[d]    = 0;
  endtask

  task automatic check_dut(input int d, input string when, input bit chg);
    tup_t g;
    g = get_out(d);
    for (int i = 0; i < 6; i++)
      check($sformatf("%s d%0d %s", when, d, fname[i]), g[i], m_pub[d][i]);
    check($sformatf("%s d%0d locked", when, d), (d == 0) ? locked0 : locked1, m_locked[d]);
    check($sformatf("%s d%0d changed", when, d), (d == 0) ? changed0 : changed1, chg);
  endtask

  task automatic pix(input bit h_s, input bit h_b, input bit v_s, input bit v_b);
    int gap;
    gap = (ce_gap_mode == 0) ? 0 : (ce_gap_mode == 1) ? 1 : int'($urandom_range(0, 1));
    ce_pix = 1'b0;
    repeat (gap) begin
      @(posedge clk_vid);
      #1;
    end
    ce_pix = 1'b1;
    HSync  = h_s;
    HBlank = h_b;
    VSync  = v_s;
    VBlank = v_b;
    @(posedge clk_vid);
    #1;
    ce_pix = 1'b0;
  endtask

  // One frame (or its first nlines lines); long_l selects a single overlong line.
  task automatic send_frame(input int long_l, input int long_len, input int last_extra,
                            input int nlines);
    tup_t nr;
    bit   novf;
    int   lt;
    nr[0] = 16'(vs);  nr[1] = 16'(va);  nr[2] = 16'(vt);
    nr[3] = 16'(hs);  nr[4] = 16'(ha);  nr[5] = 16'(ht + last_extra);
    novf  = (long_l >= 0 && long_len > HMAX1) || (ht + last_extra > HMAX1);
    for (int l = 0; l < nlines; l++) begin
      lt = (l == long_l) ? long_len : (l == vt - 1) ? ht + last_extra : ht;
      for (int p = 0; p < lt; p++) begin
        pix(p < hs, p < lt - ha, l < vs, l < vt - va);
        if (l == 0 && p == 0) begin
          for (int d = 0; d < 2; d++) begin
            check($sformatf("pulse count d%0d", d), seen[d], m_nchg[d]);
            model_end(d, rec, (d == 1) ? rec_ovf1 : 1'b0);
            check_dut(d, "frame", exp_chg[d]);
          end
        end
      end
    end
    rec      = nr;
    rec_ovf1 = novf;
  endtask

  task automatic new_timing();
    vt = int'($urandom_range(8, 16));
    va = vt - int'($urandom_range(3, 5));
    vs = int'($urandom_range(1, 2));
    ht = int'($urandom_range(16, 32));
    ha = ht - int'($urandom_range(4, 8));
    hs = int'($urandom_range(2, 4));
  endtask

  initial begin
    int k;
    reset_n = 1'b0; ce_pix = 1'b0; HSync = 1'b0; VSync = 1'b0; HBlank = 1'b0; VBlank = 1'b0;
    ce_gap_mode = 1;
    rec = '0;
    rec_ovf1 = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_nchg[d] = 0;
      seen[d]   = 0;
      model_clear(d, 1'b0);
    end
    repeat (3) @(posedge clk_vid);
    #1;
    for (int d = 0; d < 2; d++) check_dut(d, "reset", 1'b0);
    reset_n = 1'b1;

    // Fixed scaled timing, pixel strobe every other clock.
    vt = 16; va = 12; vs = 2; ht = 32; ha = 26; hs = 4;
    repeat (4) send_frame(-1, 0, 0, vt);

    // One frame whose last line is one pixel longer.
    send_frame(-1, 0, 1, vt);
    repeat (3) send_frame(-1, 0, 0, vt);

    // Mid-frame overlong line: saturates the narrow instance only.
    send_frame(3, 70, 0, vt);
    repeat (2) send_frame(-1, 0, 0, vt);

    // Stopped video: wide instance times out, narrow one keeps waiting.
    ce_pix = 1'b0;
    HSync  = 1'b0;
    repeat (1200) @(posedge clk_vid);
    #1;
    model_clear(0, 1'b1);
    for (int d = 0; d < 2; d++) begin
      check_dut(d, "timeout", 1'b0);
      check($sformatf("timeout pulse count d%0d", d), seen[d], m_nchg[d]);
    end
    repeat (3) send_frame(-1, 0, 0, vt);

    // Asynchronous reset in the middle of a frame.
    send_frame(-1, 0, 0, vt / 2);
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      model_clear(d, 1'b0);
      check_dut(d, "async reset", 1'b0);
    end
    repeat (2) @(posedge clk_vid);
    #1;
    reset_n = 1'b1;

    // Every frame overflows the narrow instance: it must never lock.
    repeat (4) send_frame(2, 70, 0, vt);

    // Continuous pixel strobe with a fresh timing.
    ce_gap_mode = 0;
    new_timing();
    repeat (3) send_frame(-1, 0, 0, vt);

    // Random mix of stable frames, timing changes, altered last lines and overflow lines.
    ce_gap_mode = 2;
    repeat (22) begin
      k = int'($urandom_range(0, 9));
      if (k == 0) new_timing();
      send_frame((k == 2) ? int'($urandom_range(1, vt - 2)) : -1, 70, (k == 1) ? 1 : 0, vt);
    end
    send_frame(-1, 0, 0, 1);

    repeat (4) @(posedge clk_vid);
    #1;
    for (int d = 0; d < 2; d++)
      check($sformatf("final pulse count d%0d", d), seen[d], m_nchg[d]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
